// File: rtl/dprf_pkg.sv
// Shared constants for the dual-port register file: read-during-write
// selection codes and the clear-engine state encoding.
package dprf_pkg;

    localparam int RDW_OLD = 0;
    localparam int RDW_NEW = 1;

    typedef logic [0:0] clr_state_t;
    localparam clr_state_t CLR_IDLE  = 1'b0;
    localparam clr_state_t CLR_SWEEP = 1'b1;

endpackage

// File: rtl/dprf_ext_if.sv
// Port bundle for dprf_ext: read-only port 1, read/write port 2 and the
// clear-engine busy flag.
interface dprf_ext_if #(
    parameter int DW = 8,
    parameter int AW = 14
);
    logic          ce1;
    logic [AW-1:0] a1;
    logic [DW-1:0] q1;
    logic          ce2;
    logic          we2;
    logic [AW-1:0] a2;
    logic [DW-1:0] d2;
    logic [DW-1:0] q2;
    logic          busy;

    modport master (
        output ce1, a1, ce2, we2, a2, d2,
        input  q1, q2, busy
    );

    modport slave (
        input  ce1, a1, ce2, we2, a2, d2,
        output q1, q2, busy
    );
endinterface

// File: rtl/dprf_clear.sv
// Post-reset clear engine: sweeps every address once, writing FILL through
// the port-2 write path, then idles until the next reset.
module dprf_clear
    import dprf_pkg::*;
#(
    parameter int  WORDS = 16384,
    parameter int  CLEAR = 1,
    localparam int AW    = $clog2(WORDS)
) (
    input  logic          clock,
    input  logic          reset,
    output logic          busy,
    output logic          clr_we,
    output logic [AW-1:0] clr_a
);

    generate
        if (CLEAR != 0) begin : g_clear
            clr_state_t    state_q, state_d;
            logic [AW-1:0] cnt_q, cnt_d;

            always_comb begin
                state_d = state_q;
                cnt_d   = cnt_q;
                if (state_q == CLR_SWEEP) begin
                    cnt_d = cnt_q + 1'b1;
                    // Terminal count is WORDS-1 so non-power-of-two depths never overrun.
                    if (cnt_q == AW'(WORDS - 1)) begin
                        state_d = CLR_IDLE;
                        cnt_d   = '0;
                    end
                end
            end

            always_ff @(posedge clock) begin
                if (reset) begin
                    state_q <= CLR_SWEEP;
                    cnt_q   <= '0;
                end else begin
                    state_q <= state_d;
                    cnt_q   <= cnt_d;
                end
            end

            assign busy   = (state_q == CLR_SWEEP);
            assign clr_we = (state_q == CLR_SWEEP);
            assign clr_a  = cnt_q;
        end else begin : g_no_clear
            assign busy   = 1'b0;
            assign clr_we = 1'b0;
            assign clr_a  = '0;
        end
    endgenerate

endmodule

// File: rtl/dprf_ext.sv
// Parametrised dual-port RAM: port 1 read-only, port 2 read/write, with
// selectable read-during-write on port 1, optional output register and
// a post-reset clear sweep.
module dprf_ext
    import dprf_pkg::*;
#(
    parameter int            DW    = 8,
    parameter int            WORDS = 16384,
    parameter int            RDW   = 0,
    parameter int            OREG  = 0,
    parameter int            CLEAR = 1,
    parameter logic [DW-1:0] FILL  = '0
) (
    input logic       clock,
    input logic       reset,
    dprf_ext_if.slave bus
);

    localparam int AW = $clog2(WORDS);

    logic [DW-1:0] mem [WORDS];

    logic          busy;
    logic          clr_we;
    logic [AW-1:0] clr_a;

    dprf_clear #(
        .WORDS (WORDS),
        .CLEAR (CLEAR)
    ) u_clear (
        .clock  (clock),
        .reset  (reset),
        .busy   (busy),
        .clr_we (clr_we),
        .clr_a  (clr_a)
    );

    logic          p2_we;
    logic          wr_en;
    logic [AW-1:0] wr_a;
    logic [DW-1:0] wr_d;

    // The sweep owns the write path while busy; port-2 writes are dropped, not queued.
    always_comb begin
        p2_we = bus.ce2 && !bus.we2 && !busy && ({1'b0, bus.a2} < (AW + 1)'(WORDS));
        wr_en = clr_we || p2_we;
        wr_a  = clr_we ? clr_a : bus.a2;
        wr_d  = clr_we ? FILL : bus.d2;
    end

    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_a] <= wr_d;
        end
    end

    logic [DW-1:0] rd1_q, rd2_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            rd1_q <= '0;
            rd2_q <= '0;
        end else begin
            if (bus.ce1) rd1_q <= mem[bus.a1];
            if (bus.ce2) rd2_q <= mem[bus.a2];
        end
    end

    // New-data bypass lives outside the array; sweep writes never bypass.
    logic          byp_q, byp_d;
    logic [DW-1:0] byp_data_q, byp_data_d;

    always_comb begin
        byp_d      = byp_q;
        byp_data_d = byp_data_q;
        if (bus.ce1) begin
            byp_d      = (RDW == RDW_NEW) && p2_we && (bus.a1 == bus.a2);
            byp_data_d = bus.d2;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            byp_q      <= 1'b0;
            byp_data_q <= '0;
        end else begin
            byp_q      <= byp_d;
            byp_data_q <= byp_data_d;
        end
    end

    logic [DW-1:0] q1_s1, q2_s1;

    assign q1_s1 = byp_q ? byp_data_q : rd1_q;
    assign q2_s1 = rd2_q;

    generate
        if (OREG != 0) begin : g_oreg
            logic [DW-1:0] q1_s2_q, q2_s2_q;

            always_ff @(posedge clock) begin
                if (reset) begin
                    q1_s2_q <= '0;
                    q2_s2_q <= '0;
                end else begin
                    q1_s2_q <= q1_s1;
                    q2_s2_q <= q2_s1;
                end
            end

            assign bus.q1 = q1_s2_q;
            assign bus.q2 = q2_s2_q;
        end else begin : g_direct
            assign bus.q1 = q1_s1;
            assign bus.q2 = q2_s1;
        end
    endgenerate

    assign bus.busy = busy;

endmodule

// File: tb/tb_dprf_ext.sv
// Scoreboard bench for dprf_ext: instance 0 (DW=8, RDW old, no output reg)
// and instance 1 (DW=16, RDW new, output reg) driven in lockstep.
module tb_dprf_ext;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dprf_ext_if #(.DW(8),  .AW(4)) bus0 ();
    dprf_ext_if #(.DW(16), .AW(4)) bus1 ();

    dprf_ext #(
        .DW(8), .WORDS(16), .RDW(0), .OREG(0), .CLEAR(1), .FILL(8'hA5)
    ) u0 (
        .clock (clk),
        .reset (rst),
        .bus   (bus0)
    );

    dprf_ext #(
        .DW(16), .WORDS(16), .RDW(1), .OREG(1), .CLEAR(1), .FILL(16'h5A5A)
    ) u1 (
        .clock (clk),
        .reset (rst),
        .bus   (bus1)
    );

    int checks = 0;
    int errors = 0;

    logic [15:0] exp0_1[$];
    logic [15:0] exp0_2[$];
    logic [15:0] exp1_1[$];
    logic [15:0] exp1_2[$];

    logic mk1 = 1'b0, mk2 = 1'b0;
    logic mk1_s1 = 1'b0, mk2_s1 = 1'b0, mk1_s2 = 1'b0, mk2_s2 = 1'b0;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
        end else begin
            $display("ok   %s val=%h t=%0t", name, act, $time);
        end
    endtask

    task automatic sb_pop(input int idx, input logic [15:0] act, input string name);
        logic [15:0] e;
        bit          have;
        have = 1'b1;
        e    = '0;
        case (idx)
            0: if (exp0_1.size() == 0) have = 1'b0; else e = exp0_1.pop_front();
            1: if (exp0_2.size() == 0) have = 1'b0; else e = exp0_2.pop_front();
            2: if (exp1_1.size() == 0) have = 1'b0; else e = exp1_1.pop_front();
            default: if (exp1_2.size() == 0) have = 1'b0; else e = exp1_2.pop_front();
        endcase
        if (!have) begin
            checks++;
            errors++;
            $display("FAIL %s scoreboard empty act=%h required=none", name, act);
        end else begin
            chk(name, act, e);
        end
    endtask

    // Marks travel with the DUT latency: one edge for u0, two edges for u1.
    always @(posedge clk) begin
        mk1_s1 <= mk1;
        mk2_s1 <= mk2;
        mk1_s2 <= mk1_s1;
        mk2_s2 <= mk2_s1;
    end

    always @(negedge clk) begin
        if (mk1_s1) sb_pop(0, {8'h00, bus0.q1}, "u0.q1");
        if (mk2_s1) sb_pop(1, {8'h00, bus0.q2}, "u0.q2");
        if (mk1_s2) sb_pop(2, bus1.q1, "u1.q1");
        if (mk2_s2) sb_pop(3, bus1.q2, "u1.q2");
    end

    task automatic drive(input logic c1e, input logic [3:0] a1, input logic c2e,
                         input logic w2, input logic [3:0] a2, input logic [15:0] d2);
        bus0.ce1 = c1e; bus0.a1 = a1; bus0.ce2 = c2e; bus0.we2 = w2; bus0.a2 = a2; bus0.d2 = d2[7:0];
        bus1.ce1 = c1e; bus1.a1 = a1; bus1.ce2 = c2e; bus1.we2 = w2; bus1.a2 = a2; bus1.d2 = d2;
    endtask

    task automatic cyc(input logic c1e, input logic [3:0] a1, input logic c2e, input logic w2,
                       input logic [3:0] a2, input logic [15:0] d2, input logic k1, input logic k2,
                       input logic [15:0] e01, input logic [15:0] e02,
                       input logic [15:0] e11, input logic [15:0] e12);
        drive(c1e, a1, c2e, w2, a2, d2);
        mk1 = k1;
        mk2 = k2;
        if (k1) begin exp0_1.push_back(e01); exp1_1.push_back(e11); end
        if (k2) begin exp0_2.push_back(e02); exp1_2.push_back(e12); end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Counts cycles with busy high; optionally attempts a write to 5 mid-sweep.
    task automatic count_busy(input bit inject, output int n);
        n = 0;
        while (bus0.busy && n < 100) begin
            n++;
            if (inject && n == 11) drive(0, 0, 1, 0, 5, 16'h003C);
            else                   drive(0, 0, 0, 1, 0, 0);
            @(negedge clk);
        end
        drive(0, 0, 0, 1, 0, 0);
    endtask

    task automatic read_all_fill();
        for (int i = 0; i < 16; i++)
            cyc(1, 4'(i), 1, 1, 4'(15 - i), 0, 1, 1, 16'h00A5, 16'h00A5, 16'h5A5A, 16'h5A5A);
        idle(3);
    endtask

    initial begin
        int n;
        rst = 1'b1;
        drive(0, 0, 0, 1, 0, 0);
        @(negedge clk);
        rst = 1'b0;

        chk("rst_u0_q1", {8'h00, bus0.q1}, 16'h0000);
        chk("rst_u0_q2", {8'h00, bus0.q2}, 16'h0000);
        chk("rst_u1_q1", bus1.q1, 16'h0000);
        chk("rst_u1_q2", bus1.q2, 16'h0000);
        chk("rst_busy0", {15'd0, bus0.busy}, 16'd1);
        chk("rst_busy1", {15'd0, bus1.busy}, 16'd1);
        count_busy(1'b0, n);
        chk("busy_len1", 16'(n), 16'd16);
        chk("busy1_low", {15'd0, bus1.busy}, 16'd0);
        read_all_fill();

        // Dirty every word, then restart the sweep partway through.
        for (int i = 0; i < 16; i++) cyc(0, 0, 1, 0, 4'(i), 16'h1100 + 16'(i), 0, 0, 0, 0, 0, 0);
        pulse_reset();
        idle(7);
        pulse_reset();
        count_busy(1'b1, n);
        chk("busy_len2", 16'(n), 16'd16);
        read_all_fill();

        cyc(0, 0, 1, 0, 5, 16'h003C, 0, 0, 0, 0, 0, 0);
        cyc(1, 5, 0, 1, 0, 0, 1, 0, 16'h003C, 0, 16'h003C, 0);
        idle(3);

        // Collision at address 9.
        cyc(0, 0, 1, 0, 9, 16'h0011, 0, 0, 0, 0, 0, 0);
        cyc(1, 9, 1, 0, 9, 16'h0077, 1, 1, 16'h0011, 16'h0011, 16'h0077, 16'h0011);
        cyc(1, 9, 0, 1, 0, 0, 1, 0, 16'h0077, 0, 16'h0077, 0);
        idle(3);

        // Latency: read 4 at N-1 then 3 at N; u1 shows FILL after N, BEEF after N+1.
        cyc(0, 0, 1, 0, 3, 16'hBEEF, 0, 0, 0, 0, 0, 0);
        cyc(1, 4, 0, 1, 0, 0, 1, 0, 16'h00A5, 0, 16'h5A5A, 0);
        cyc(1, 3, 0, 1, 0, 0, 1, 0, 16'h00EF, 0, 16'hBEEF, 0);
        for (int k = 0; k < 4; k++)
            cyc(0, 4'(k + 7), 0, 1, 0, 0, 1, 0, 16'h00EF, 0, 16'hBEEF, 0);
        idle(3);

        pulse_reset();
        chk("rst2_u0_q1", {8'h00, bus0.q1}, 16'h0000);
        chk("rst2_u0_q2", {8'h00, bus0.q2}, 16'h0000);
        chk("rst2_u1_q1", bus1.q1, 16'h0000);
        chk("rst2_u1_q2", bus1.q2, 16'h0000);
        chk("rst2_busy", {15'd0, bus0.busy}, 16'd1);
        count_busy(1'b0, n);
        chk("busy_len3", 16'(n), 16'd16);

        chk("sb_left", 16'(exp0_1.size() + exp0_2.size() + exp1_1.size() + exp1_2.size()), 16'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout act=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
